xadac_mem_arbiter: RTL

- Shares one single-beat memory request port between two requesters; the memory port feeds the external dcache request path.
- Requester 0 is the xadac AXI-to-dcache adapter read path; requester 1 is its write path.
- Round-robin grant; in-order response routing through an outstanding-transaction FIFO.
- Sits between the AXI-to-dcache adapter and the external dcache port of the core.

---
 rtl/xadac_pkg.sv | 19 +
 rtl/xadac_id_fifo.sv | 51 +++++
 rtl/xadac_mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/xadac_pkg.sv
// Shared types and constants for the xadac AXI-to-dcache memory path.
package xadac_pkg;

   localparam int XadacMemMaxOutstanding = 4;
   localparam int XadacAddrWidth         = 64;
   localparam int XadacDataWidth         = 64;

   typedef struct packed {
      logic [XadacAddrWidth-1:0]   addr;
      logic                        we;
      logic [XadacDataWidth-1:0]   wdata;
      logic [XadacDataWidth/8-1:0] be;
   } xadac_mem_req_t;

   typedef struct packed {
      logic [XadacDataWidth-1:0] rdata;
   } xadac_mem_rsp_t;

endpackage

// File: rtl/xadac_id_fifo.sv
// Outstanding-transaction FIFO holding the requester id of each accepted request.
// A push while full succeeds when a pop happens in the same cycle.
module xadac_id_fifo #(
   parameter int Depth = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic data_i,
   input  logic pop_i,
   output logic head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PtrW = $clog2(Depth);
   localparam logic [PtrW:0] DepthC = (PtrW+1)'(Depth);

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic [Depth-1:0] mem_q;
   logic            do_push, do_pop;

   assign full_o  = (count_q == DepthC);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only read once count_q says it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/xadac_mem_arbiter.sv
// Round-robin arbiter sharing one single-beat dcache request port between the
// adapter read (0) and write (1) paths, with in-order response routing.
module xadac_mem_arbiter
   import xadac_pkg::*;
#(
   parameter int AddrWidth      = XadacAddrWidth,
   parameter int DataWidth      = XadacDataWidth,
   parameter int MaxOutstanding = XadacMemMaxOutstanding
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [1:0]                      req_valid_i,
   output logic [1:0]                      req_ready_o,
   input  logic [1:0][AddrWidth-1:0]       req_addr_i,
   input  logic [1:0]                      req_we_i,
   input  logic [1:0][DataWidth-1:0]       req_wdata_i,
   input  logic [1:0][DataWidth/8-1:0]     req_be_i,
   output logic [1:0]                      rsp_valid_o,
   output logic [DataWidth-1:0]            rsp_rdata_o,
   output logic                            mem_req_valid_o,
   input  logic                            mem_req_ready_i,
   output logic [AddrWidth-1:0]            mem_req_addr_o,
   output logic                            mem_req_we_o,
   output logic [DataWidth-1:0]            mem_req_wdata_o,
   output logic [DataWidth/8-1:0]          mem_req_be_o,
   input  logic                            mem_rsp_valid_i,
   input  logic [DataWidth-1:0]            mem_rsp_rdata_i,
   output logic                            err_o
);

   typedef struct packed {
      logic [AddrWidth-1:0]   addr;
      logic                   we;
      logic [DataWidth-1:0]   wdata;
      logic [DataWidth/8-1:0] be;
   } req_t;

   req_t [1:0] reqs;
   req_t       granted;

   logic rr_ptr_q, rr_ptr_d;
   logic lock_q, lock_d;
   logic sel_q, sel_d;
   logic err_q, err_d;
   logic sel, can_push, handshake, pop;
   logic fifo_full, fifo_empty, fifo_head;

   for (genvar i = 0; i < 2; i++) begin : g_req
      assign reqs[i] = '{addr: req_addr_i[i], we: req_we_i[i],
                         wdata: req_wdata_i[i], be: req_be_i[i]};
   end

   // A stalled request keeps its requester even if the other one raises valid.
   assign sel       = lock_q ? sel_q : (req_valid_i[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q);
   assign can_push  = !fifo_full || mem_rsp_valid_i;
   assign granted   = reqs[sel];
   assign handshake = mem_req_valid_o && mem_req_ready_i;
   assign pop       = !rst && mem_rsp_valid_i && !fifo_empty;

   assign mem_req_valid_o = !rst && (|req_valid_i) && can_push;
   assign mem_req_addr_o  = granted.addr;
   assign mem_req_we_o    = granted.we;
   assign mem_req_wdata_o = granted.wdata;
   assign mem_req_be_o    = granted.be;
   assign rsp_rdata_o     = mem_rsp_rdata_i;
   assign err_o           = err_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (!rst && mem_req_ready_i && can_push) req_ready_o[sel] = 1'b1;
      if (pop) rsp_valid_o[fifo_head] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = handshake ? ~sel : rr_ptr_q;
      lock_d   = mem_req_valid_o && !mem_req_ready_i;
      sel_d    = sel;
      err_d    = err_q || (mem_rsp_valid_i && fifo_empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
         lock_q   <= 1'b0;
         sel_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         lock_q   <= lock_d;
         sel_q    <= sel_d;
         err_q    <= err_d;
      end
   end

   xadac_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (handshake),
      .data_i  (sel),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule
